// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//
// Registered immediate-extension stage for the decode -> execute path.
// An IN_W-bit immediate is widened to OUT_W bits in one of four modes
// (zero, sign, load-upper, word branch offset). The widened value travels
// with its mode and a sideband tag through a 2-entry skid buffer that has
// valid/ready handshakes on both sides. A synchronous flush squashes both
// entries.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of all buffered items
//   in_valid   upstream item present
//   in_ready   stage can accept an item this cycle
//   in_imm     raw immediate            [IN_W-1:0]
//   in_mode    00 zero, 01 sign, 10 upper, 11 branch
//   in_tag     sideband tag             [TAG_W-1:0]
//   out_valid  extended item present
//   out_ready  downstream accepts this cycle
//   out_imm    extended immediate       [OUT_W-1:0]
//   out_tag    tag belonging to out_imm [TAG_W-1:0]
//   out_mode   mode used for out_imm
// -----------------------------------------------------------------------------
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_mode
);

    localparam int PAD = OUT_W - IN_W;

    // The branch mode needs two spare bits above the sign-extended immediate.
    if (OUT_W < IN_W + 2) begin : gWidthCheck
        $error("imm_extend_stage: OUT_W must be at least IN_W+2");
    end

    typedef struct packed {
        logic [OUT_W-1:0] imm;
        logic [TAG_W-1:0] tag;
        logic [1:0]       mode;
    } entry_t;

    entry_t     mainEntry, skidEntry, newEntry;
    logic       mainValid, skidValid;
    logic [OUT_W-1:0] signExt, extImm;
    logic       accept, take;

    // Sign-extended immediate is shared by the sign and branch modes. The
    // branch offset is this value shifted by two; with PAD >= 2 nothing
    // significant is shifted out, and PAD == 2 needs no zero-width replicate.
    assign signExt = {{PAD{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        extImm = '0;
        case (in_mode)
            2'b00:   extImm = {{PAD{1'b0}}, in_imm};
            2'b01:   extImm = signExt;
            2'b10:   extImm = {in_imm, {PAD{1'b0}}};
            default: extImm = signExt << 2;
        endcase
    end

    assign newEntry = '{imm: extImm, tag: in_tag, mode: in_mode};

    // in_ready depends only on registered state and flush, never on
    // out_ready, so there is no combinational path across the stage.
    assign in_ready  = !skidValid && !flush;
    assign out_valid = mainValid;
    assign accept    = in_valid && in_ready;
    assign take      = mainValid && out_ready;

    assign out_imm  = mainEntry.imm;
    assign out_tag  = mainEntry.tag;
    assign out_mode = mainEntry.mode;

    // Main holds the oldest item and drives the outputs; skid holds the
    // second-oldest. A new item enters skid only when main is stalled, and
    // skid is never written while full because in_ready is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well, so the outputs read zero during and after reset.
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainEntry <= '0;
            skidEntry <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
            if (take) begin
                if (skidValid) begin
                    mainEntry <= skidEntry;
                    skidValid <= 1'b0;
                end else if (accept) begin
                    mainEntry <= newEntry;
                end else begin
                    mainValid <= 1'b0;
                end
            end else if (mainValid) begin
                if (accept) begin
                    skidEntry <= newEntry;
                    skidValid <= 1'b1;
                end
            end else if (accept) begin
                mainEntry <= newEntry;
                mainValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_stage
//
// Self-checking bench for imm_extend_stage (IN_W=16, OUT_W=32, TAG_W=5).
// The reference model is a capacity-2 FIFO of already-extended items; the
// extension itself is computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_imm_extend_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic [1:0]  out_mode;

    imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic [1:0]  mode;
    } item_t;

    item_t modelQ[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] refExt(input logic [15:0] e, input logic [1:0] m);
        longint u, s;
        u = longint'(e);
        s = (u >= 32768) ? u - 65536 : u;
        case (m)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, advance
    // across the rising edge. Entered and left at posedge+1.
    task automatic cycle(input bit v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input bit r, input bit fl);
        bit acc, tk;
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = r;
        flush     = fl;
        #1;
        check("out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
        check("in_ready",  32'(in_ready),  32'(modelQ.size() < 2 && !fl));
        if (modelQ.size() > 0) begin
            check("out_imm",  out_imm,        modelQ[0].imm);
            check("out_tag",  32'(out_tag),   32'(modelQ[0].tag));
            check("out_mode", 32'(out_mode),  32'(modelQ[0].mode));
        end
        acc = v && (modelQ.size() < 2) && !fl;
        tk  = (modelQ.size() > 0) && r;
        @(posedge clk);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (tk)  void'(modelQ.pop_front());
            if (acc) modelQ.push_back('{imm: refExt(imm, mode), tag: tag, mode: mode});
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    endtask

    logic [31:0] modeExp [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        // Reset state before any clock edge.
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm",   out_imm,        32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_out_mode",  32'(out_mode),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four modes back to back, one-cycle latency.
        for (int m = 0; m < 4; m++) begin
            cycle(1'b1, 16'h8001, 2'(m), 5'(m + 1), 1'b1, 1'b0);
            check("mode_imm", out_imm,      modeExp[m]);
            check("mode_tag", 32'(out_tag), 32'(m + 1));
        end
        idle(2);

        // Branch offset sign handling.
        cycle(1'b1, 16'hFFFF, 2'd3, 5'd9, 1'b1, 1'b0);
        check("br_neg", out_imm, 32'hFFFFFFFC);
        cycle(1'b1, 16'h7FFF, 2'd3, 5'd10, 1'b1, 1'b0);
        check("br_pos", out_imm, 32'h0001FFFC);
        idle(2);

        // Backpressure: A, B accepted, C held until skid drains.
        cycle(1'b1, 16'h0001, 2'd0, 5'd1, 1'b0, 1'b0);
        check("bp_a_out", out_imm, 32'h1);
        cycle(1'b1, 16'h0002, 2'd0, 5'd2, 1'b0, 1'b0);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'h0003, 2'd0, 5'd3, 1'b0, 1'b0);
        check("bp_stable", out_imm, 32'h1);
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'h0003, 2'd0, 5'd3, 1'b1, 1'b0);
        check("bp_b_out", out_imm, 32'h2);
        cycle(1'b1, 16'h0003, 2'd0, 5'd3, 1'b1, 1'b0);
        check("bp_c_out", out_imm, 32'h3);
        idle(2);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and an item offered.
        cycle(1'b1, 16'h0010, 2'd1, 5'd4, 1'b0, 1'b0);
        cycle(1'b1, 16'h0011, 2'd1, 5'd5, 1'b0, 1'b0);
        cycle(1'b1, 16'h00AA, 2'd0, 5'd7, 1'b0, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        idle(3);

        // Asynchronous reset between edges with two items buffered.
        cycle(1'b1, 16'h0055, 2'd2, 5'd6, 1'b0, 1'b0);
        cycle(1'b1, 16'h0066, 2'd2, 5'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_imm",   out_imm,        32'd0);
        check("ar_in_ready",  32'(in_ready),  32'd1);
        modelQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 16'h1234, 2'd2, 5'd11, 1'b1, 1'b0);
        check("ar_first_item", out_imm, 32'h12340000);
        idle(2);

        // Random streaming against the FIFO model.
        begin
            int         accepted = 0;
            int         cyc      = 0;
            bit         havePend = 0;
            logic [15:0] pImm;
            logic [1:0]  pMode;
            logic [4:0]  pTag;
            while (accepted < 1000 && cyc < 20000) begin
                bit v, r, fl, acc;
                if (!havePend) begin
                    pImm     = 16'($urandom);
                    pMode    = 2'($urandom_range(0, 3));
                    pTag     = 5'($urandom_range(0, 31));
                    havePend = 1;
                end
                v   = 1'($urandom_range(0, 1));
                r   = 1'($urandom_range(0, 1));
                fl  = ($urandom_range(0, 49) == 0);
                acc = v && (modelQ.size() < 2) && !fl;
                cycle(v, pImm, pMode, pTag, r, fl);
                if (acc) begin
                    havePend = 0;
                    accepted++;
                end
                cyc++;
            end
            for (int i = 0; i < 4 && modelQ.size() > 0; i++) idle(1);
            idle(1);
            check("stream_drained", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
